// File: rtl/rca_commit_unit.sv
// rtl/rca_commit_unit.sv - RCA result buffer and one-per-cycle retire/writeback stage
// Results queue in order, retire on rf_grant, and reach the register file one cycle later.
module rca_commit_unit #(
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ID_W            = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int XLEN            = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            result_valid,
  output logic                            result_ready,
  input  logic [ID_W-1:0]                 result_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0] result_data,
  input  logic [NUM_WRITE_PORTS-1:0]      result_we,
  input  logic                            rf_grant,
  output logic                            rca_retired,
  output logic [ID_W-1:0]                 rca_id_retiring,
  input  logic [NUM_WRITE_PORTS*5-1:0]    rca_retired_rd_addrs,
  input  logic [ID_W-1:0]                 rca_id_for_rds,
  output logic [NUM_WRITE_PORTS-1:0]      rf_we,
  output logic [NUM_WRITE_PORTS*5-1:0]    rf_waddr,
  output logic [NUM_WRITE_PORTS*XLEN-1:0] rf_wdata,
  output logic                            rf_clear_inuse,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            dup_id_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]                 id_q   [FIFO_DEPTH];
  logic [ID_W-1:0]                 id_d   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] data_q [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] data_d [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS-1:0]      we_q   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS-1:0]      we_d   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]           slot_valid_q, slot_valid_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;

  logic                            wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]                 wb_id_q, wb_id_d;
  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_data_q, wb_data_d;
  logic [NUM_WRITE_PORTS-1:0]      wb_we_q, wb_we_d;
  logic [NUM_WRITE_PORTS*5-1:0]    wb_addr_q, wb_addr_d;
  logic                            wb_match_q, wb_match_d;
  logic                            dup_q, dup_d;

  logic empty, full, push, retire, dup_hit;
  logic [ID_W-1:0] head_id;
  logic [NUM_WRITE_PORTS-1:0] base_we;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push    = result_valid & ~full;
  assign retire  = ~empty & rf_grant;
  assign head_id = id_q[rd_ptr_q];

  // Duplicate check covers both buffered entries and the result sitting in writeback.
  always_comb begin
    dup_hit = wb_valid_q && (wb_id_q == result_id);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (slot_valid_q[k] && (id_q[k] == result_id)) dup_hit = 1'b1;
    end
  end

  always_comb begin
    id_d         = id_q;
    data_d       = data_q;
    we_d         = we_q;
    slot_valid_d = slot_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wb_valid_d   = retire;
    wb_id_d      = wb_id_q;
    wb_data_d    = wb_data_q;
    wb_we_d      = wb_we_q;
    wb_addr_d    = wb_addr_q;
    wb_match_d   = wb_match_q;
    dup_d        = dup_q | (push & dup_hit);

    if (push) begin
      id_d[wr_ptr_q]         = result_id;
      data_d[wr_ptr_q]       = result_data;
      we_d[wr_ptr_q]         = result_we;
      slot_valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end

    if (retire) begin
      slot_valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d               = rd_ptr_q + PTR_W'(1);
      wb_id_d                = head_id;
      wb_data_d              = data_q[rd_ptr_q];
      wb_we_d                = we_q[rd_ptr_q];
      wb_addr_d              = rca_retired_rd_addrs;
      wb_match_d             = (rca_id_for_rds == head_id);
    end

    case ({push, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        id_q[k]   <= '0;
        data_q[k] <= '0;
        we_q[k]   <= '0;
      end
      slot_valid_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_id_q      <= '0;
      wb_data_q    <= '0;
      wb_we_q      <= '0;
      wb_addr_q    <= '0;
      wb_match_q   <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      id_q         <= id_d;
      data_q       <= data_d;
      we_q         <= we_d;
      slot_valid_q <= slot_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wb_valid_q   <= wb_valid_d;
      wb_id_q      <= wb_id_d;
      wb_data_q    <= wb_data_d;
      wb_we_q      <= wb_we_d;
      wb_addr_q    <= wb_addr_d;
      wb_match_q   <= wb_match_d;
      dup_q        <= dup_d;
    end
  end

  // x0 is never written; when two ports share an rd the highest-index one wins.
  always_comb begin
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      base_we[i] = wb_valid_q & wb_we_q[i] & (wb_addr_q[i*5 +: 5] != 5'd0);
    end
    rf_we = base_we;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
        if (base_we[j] && (wb_addr_q[j*5 +: 5] == wb_addr_q[i*5 +: 5])) rf_we[i] = 1'b0;
      end
    end
  end

  assign result_ready    = ~full;
  assign rca_retired     = retire;
  assign rca_id_retiring = empty ? '0 : head_id;
  assign rf_waddr        = wb_addr_q;
  assign rf_wdata        = wb_data_q;
  assign rf_clear_inuse  = wb_valid_q & wb_match_q;
  assign fifo_count      = count_q;
  assign dup_id_error    = dup_q;

endmodule

// File: tb/tb_rca_commit_unit.sv
// tb/tb_rca_commit_unit.sv - directed self-checking bench for rca_commit_unit
module tb_rca_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        result_valid;
  logic        result_ready;
  logic [2:0]  result_id;
  logic [63:0] result_data;
  logic [1:0]  result_we;
  logic        rf_grant;
  logic        rca_retired;
  logic [2:0]  rca_id_retiring;
  logic [9:0]  rca_retired_rd_addrs;
  logic [2:0]  rca_id_for_rds;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_clear_inuse;
  logic [2:0]  fifo_count;
  logic        dup_id_error;

  int checks = 0;
  int errors = 0;
  logic [2:0] ids [4];

  rca_commit_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_id            (result_id),
    .result_data          (result_data),
    .result_we            (result_we),
    .rf_grant             (rf_grant),
    .rca_retired          (rca_retired),
    .rca_id_retiring      (rca_id_retiring),
    .rca_retired_rd_addrs (rca_retired_rd_addrs),
    .rca_id_for_rds       (rca_id_for_rds),
    .rf_we                (rf_we),
    .rf_waddr             (rf_waddr),
    .rf_wdata             (rf_wdata),
    .rf_clear_inuse       (rf_clear_inuse),
    .fifo_count           (fifo_count),
    .dup_id_error         (dup_id_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ids[0] = 3'd0; ids[1] = 3'd1; ids[2] = 3'd3; ids[3] = 3'd5;
    rst_n = 1'b0;
    result_valid = 1'b0;
    result_id = '0;
    result_data = '0;
    result_we = '0;
    rf_grant = 1'b1;
    rca_retired_rd_addrs = '0;
    rca_id_for_rds = '0;
    step();
    step();
    chk("rst_ready", result_ready, 1'b1);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_retired", rca_retired, 1'b0);
    chk("rst_id", rca_id_retiring, 3'd0);
    chk("rst_we", rf_we, 2'b00);
    chk("rst_clear", rf_clear_inuse, 1'b0);
    chk("rst_dup", dup_id_error, 1'b0);
    rst_n = 1'b1;

    // single result, both ports, rd {5,6}
    result_valid = 1'b1; result_id = 3'd2; result_we = 2'b11;
    result_data = {32'hBBBB0002, 32'hAAAA0002};
    #1;
    chk("t1_no_bypass", rca_retired, 1'b0);
    step();
    result_valid = 1'b0;
    rca_retired_rd_addrs = {5'd6, 5'd5}; rca_id_for_rds = 3'd2;
    #1;
    chk("t1_retired", rca_retired, 1'b1);
    chk("t1_id", rca_id_retiring, 3'd2);
    chk("t1_count", fifo_count, 3'd1);
    chk("t1_we_early", rf_we, 2'b00);
    step();
    chk("t1_we", rf_we, 2'b11);
    chk("t1_waddr0", rf_waddr[4:0], 5'd5);
    chk("t1_waddr1", rf_waddr[9:5], 5'd6);
    chk("t1_wdata", rf_wdata, 64'hBBBB0002AAAA0002);
    chk("t1_clear", rf_clear_inuse, 1'b1);
    chk("t1_count0", fifo_count, 3'd0);
    chk("t1_retired0", rca_retired, 1'b0);
    step();
    chk("t1_we_once", rf_we, 2'b00);

    // fill with grant low, then drain in order
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      result_valid = 1'b1; result_id = ids[i]; result_we = 2'b01;
      result_data = {32'h0, 32'h100 + i};
      step();
    end
    chk("t2_full_ready", result_ready, 1'b0);
    chk("t2_full_count", fifo_count, 3'd4);
    chk("t2_no_grant", rca_retired, 1'b0);
    result_id = 3'd6;
    step();
    chk("t2_full_hold", fifo_count, 3'd4);
    chk("t2_no_dup", dup_id_error, 1'b0);
    result_valid = 1'b0;
    rf_grant = 1'b1;
    rca_retired_rd_addrs = {5'd11, 5'd10}; rca_id_for_rds = 3'd7;
    #1;
    chk("t2_full_no_credit", result_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_retired", rca_retired, 1'b1);
      chk("t2_order", rca_id_retiring, ids[i]);
      if (i > 0) begin
        chk("t2_we", rf_we, 2'b01);
        chk("t2_wdata", rf_wdata[31:0], 32'h100 + i - 1);
      end
      step();
    end
    chk("t2_drained", fifo_count, 3'd0);
    chk("t2_empty_no_retire", rca_retired, 1'b0);
    chk("t2_last_we", rf_we, 2'b01);
    chk("t2_last_wdata", rf_wdata[31:0], 32'h103);
    chk("t2_clear0", rf_clear_inuse, 1'b0);
    step();
    chk("t2_we_idle", rf_we, 2'b00);

    // x0 suppression, then same-rd collision, with push+pop overlap
    result_valid = 1'b1; result_id = 3'd1; result_we = 2'b11;
    result_data = {32'h11, 32'h10};
    step();
    result_id = 3'd4; result_data = {32'h41, 32'h40};
    rca_retired_rd_addrs = {5'd7, 5'd0}; rca_id_for_rds = 3'd3;
    #1;
    chk("t3_retired", rca_retired, 1'b1);
    chk("t3_id", rca_id_retiring, 3'd1);
    step();
    result_valid = 1'b0;
    chk("t3_pushpop_count", fifo_count, 3'd1);
    chk("t3_x0_we", rf_we, 2'b10);
    chk("t3_waddr1", rf_waddr[9:5], 5'd7);
    chk("t3_clear_mismatch", rf_clear_inuse, 1'b0);
    rca_retired_rd_addrs = {5'd9, 5'd9}; rca_id_for_rds = 3'd4;
    #1;
    chk("t3_id2", rca_id_retiring, 3'd4);
    step();
    chk("t3_same_rd_we", rf_we, 2'b10);
    chk("t3_same_rd_addr", rf_waddr[9:5], 5'd9);
    chk("t3_clear_match", rf_clear_inuse, 1'b1);
    chk("t3_count0", fifo_count, 3'd0);
    chk("t3_dup0", dup_id_error, 1'b0);

    // duplicate ID detection and reset mid-operation
    rf_grant = 1'b0;
    step();
    result_valid = 1'b1; result_id = 3'd4; result_we = 2'b11;
    step();
    chk("t4_dup_first", dup_id_error, 1'b0);
    step();
    chk("t4_dup_set", dup_id_error, 1'b1);
    chk("t4_count2", fifo_count, 3'd2);
    result_id = 3'd6;
    step();
    result_id = 3'd7;
    step();
    result_valid = 1'b0;
    chk("t4_count4", fifo_count, 3'd4);
    chk("t4_dup_sticky", dup_id_error, 1'b1);
    rf_grant = 1'b1;
    rca_retired_rd_addrs = {5'd2, 5'd1}; rca_id_for_rds = 3'd0;
    step();
    chk("t4_wb_we", rf_we, 2'b11);
    chk("t4_count3", fifo_count, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_we", rf_we, 2'b00);
    chk("t4_rst_count", fifo_count, 3'd0);
    chk("t4_rst_retired", rca_retired, 1'b0);
    chk("t4_rst_id", rca_id_retiring, 3'd0);
    chk("t4_rst_ready", result_ready, 1'b1);
    chk("t4_rst_dup", dup_id_error, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_post_we", rf_we, 2'b00);
      chk("t4_post_retired", rca_retired, 1'b0);
      chk("t4_post_count", fifo_count, 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
